commit_unit: RTL and testbench
==============================

# commit_unit

In-order retirement controller that sequences the reorder buffer head. Each cycle it inspects the ROB head and retires at most one instruction:
- register-writing ALU/load results go to the architectural register file;
- stores are sent to memory through a req/ack handshake;
- mispredicted branches raise a pipeline flush and a PC redirect.

It is the sole driver of the ROB `rd_en` dequeue strobe, and it keeps a retired-instruction counter.

## Interface
- `FLUSH_CYCLES`, 2: stall cycles after a flush before retirement resumes (≥1).
- `CNT_W`, 32: width of the retired-instruction counter.

- `clk`  in  1  core clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `head`  in  ROB_entry_t  ROB head entry. Fields used: `itype`, `ready`, `dest_reg[4:0]`, `value[31:0]`, `addr[31:0]`, `branch_result`, `ROB_number[3:0]`.
- `head_ready`  in  1  `head.ready`.
- `rob_empty`  in  1  ROB holds no valid entries.
- `store_ack`  in  1  memory accepted the current store.
- `rd_en`  out  1  dequeue ROB head this cycle.
- `rf_wr_en`  out  1  register file write strobe.
- `rf_wr_addr`  out  5  destination register.
- `rf_wr_data`  out  32  write data.
- `rf_wr_tag`  out  4  ROB_number of the retiring entry; the RAT clears its mapping if the tag matches.
- `store_req`  out  1  store request, held until ack.
- `store_addr`  out  32  store address.
- `store_data`  out  32  store data.
- `flush`  out  1  one-cycle pulse: flush ROB, RS and RAT.
- `redirect_pc`  out  32  fetch target, valid while `flush`=1.
- `retired_count`  out  CNT_W  number of instructions retired.

## Operation
- itype encoding: 00 branch, 01 store, 10 ALU, 11 load.
- FSM states: RETIRE, STORE_WAIT, FLUSH_WAIT.
- **RETIRE**: the head is eligible when `!rob_empty && head_ready`. If not eligible, all strobes are 0 and the state is held.
  - **ALU/load**: `rf_wr_en`=1, `rf_wr_addr`=`dest_reg`, `rf_wr_data`=`value`, `rf_wr_tag`=`ROB_number`, `rd_en`=1, all in the same cycle. Stay in RETIRE.
  - **Store**: no `rd_en`. Latch `addr` into `store_addr` and `value` into `store_data`, then go to STORE_WAIT.
  - **Branch, `branch_result`=0** (correctly predicted): `rd_en`=1, no other effect.
  - **Branch, `branch_result`=1** (mispredicted): `rd_en`=1, `flush`=1, `redirect_pc`=`value`. Load the stall counter with FLUSH_CYCLES and go to FLUSH_WAIT.
- **STORE_WAIT**: `store_req`=1 and the latched address/data are held stable. In the cycle where `store_ack`=1: `rd_en`=1, `store_req` drops the following cycle, return to RETIRE. There is no timeout.
- **FLUSH_WAIT**: no strobes. The counter decrements once per cycle; when it reaches 0, go to RETIRE. `head` and `rob_empty` are ignored in this state.
- `retired_count` increments by 1 in every cycle where `rd_en`=1. It wraps modulo 2^CNT_W.
- Register writes go only through the ALU/load path. `dest_reg`=0 is still written; the register file ignores x0.

## Timing
- The retire decision has 0-cycle latency: `rd_en`, `rf_*`, `flush` and `redirect_pc` are combinational from the state plus `head`, `head_ready` and `rob_empty`. No combinational path from `store_ack` reaches `store_req`.
- Throughput is 1 ALU/load/branch retirement per cycle.
- A store takes at least 2 cycles: the detect cycle, then ack cycles. If ack arrives in the first STORE_WAIT cycle, `rd_en` is asserted at detect+1.
- After a mispredict in cycle N, the next retirement is possible in cycle N+1+FLUSH_CYCLES.
- `store_ack` outside STORE_WAIT is ignored.
- Reset (asynchronous, any state, including mid-store) forces:
  - state RETIRE;
  - `store_req`=0, `store_addr`=0, `store_data`=0;
  - stall counter 0, `retired_count`=0.

  All combinational strobes are 0 while `reset_n`=0. A pending store is abandoned and is not re-issued.

## Structure
- Shared package `structs.svh` gets:
  - ROB_entry_t with the `dest_reg` and `addr` fields added;
  - ITYPE_BRANCH/STORE/ALU/LOAD localparams;
  - `commit_state_t` enum.
- The ROB must export its `empty` signal as `rob_empty`.
- One sub-module: `flush_stall_timer`, a loadable down-counter of width $clog2(FLUSH_CYCLES+1) with load, count and zero outputs.

## Test plan
- ALU head: ready, `dest_reg`=5, `value`=0xDEADBEEF, `ROB_number`=3 → same cycle `rf_wr_en`=1, addr 5, data 0xDEADBEEF, tag 3, `rd_en`=1; `retired_count` 0→1.
- Store head: `addr`=0x100, `value`=0x55, `store_ack` delayed 3 cycles → `store_req` high for exactly 3 cycles with 0x100/0x55 stable; `rd_en` only in the ack cycle.
- Mispredicted branch with `value`=0x2000, FLUSH_CYCLES=2 → `flush` high for 1 cycle with `redirect_pc`=0x2000; `rd_en` stays 0 for the next 2 cycles despite a ready head.
- `rob_empty`=1 with `head_ready`=1 (stale entry) → no strobes and the count is unchanged. Also: `head_ready`=0 → no strobes.
- Assert `reset_n` low in the 2nd STORE_WAIT cycle → `store_req` drops immediately, `retired_count`=0, and after release the FSM is in RETIRE.
- Preload `retired_count` to 0xFFFFFFFF via back-to-back ALU retirements, then retire one more → the counter wraps to 0.

Source files
------------

// File: rtl/commit_unit_pkg.sv
// Shared types for the commit unit: ROB head entry layout, instruction type codes, FSM states.
package commit_unit_pkg;

  localparam logic [1:0] ITYPE_BRANCH = 2'b00;
  localparam logic [1:0] ITYPE_STORE  = 2'b01;
  localparam logic [1:0] ITYPE_ALU    = 2'b10;
  localparam logic [1:0] ITYPE_LOAD   = 2'b11;

  typedef struct packed {
    logic [1:0]  itype;
    logic        ready;
    logic [4:0]  dest_reg;
    logic [31:0] value;
    logic [31:0] addr;
    logic        branch_result;
    logic [3:0]  ROB_number;
  } ROB_entry_t;

  typedef enum logic [1:0] {
    RETIRE     = 2'd0,
    STORE_WAIT = 2'd1,
    FLUSH_WAIT = 2'd2
  } commit_state_t;

endpackage

// File: rtl/commit_unit_flush_stall_timer.sv
// Loadable down-counter that holds off retirement for a fixed number of cycles after a flush.
module flush_stall_timer #(
  parameter  int unsigned MAX_COUNT = 2,
  localparam int unsigned W         = $clog2(MAX_COUNT + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load_i,
  input  logic count_i,
  output logic zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // zero_o looks at the next value so the owner can leave its wait state on time
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = W'(MAX_COUNT);
    end else if (count_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
    zero_o = (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/commit_unit.sv
// In-order retirement controller: retires at most one ROB head entry per cycle to the
// register file, the store port, or the flush/redirect path.
module commit_unit
  import commit_unit_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  ROB_entry_t       head,
  input  logic             head_ready,
  input  logic             rob_empty,
  input  logic             store_ack,
  output logic             rd_en,
  output logic             rf_wr_en,
  output logic [4:0]       rf_wr_addr,
  output logic [31:0]      rf_wr_data,
  output logic [3:0]       rf_wr_tag,
  output logic             store_req,
  output logic [31:0]      store_addr,
  output logic [31:0]      store_data,
  output logic             flush,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] retired_count
);

  commit_state_t    state_q, state_d;
  logic             store_req_q, store_req_d;
  logic [31:0]      store_addr_q, store_addr_d;
  logic [31:0]      store_data_q, store_data_d;
  logic [CNT_W-1:0] retired_count_q, retired_count_d;

  logic eligible;
  logic timer_load;
  logic timer_count;
  logic timer_zero;
  logic unused_head_ready_bit;

  // head_ready is the authoritative copy of the entry's ready bit
  assign unused_head_ready_bit = head.ready;

  flush_stall_timer #(
    .MAX_COUNT (FLUSH_CYCLES)
  ) u_flush_stall_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (timer_load),
    .count_i (timer_count),
    .zero_o  (timer_zero)
  );

  // Retire decision: strobes are combinational from state and head, gated off in reset
  always_comb begin
    state_d      = state_q;
    store_addr_d = store_addr_q;
    store_data_d = store_data_q;
    rd_en        = 1'b0;
    rf_wr_en     = 1'b0;
    rf_wr_addr   = 5'd0;
    rf_wr_data   = 32'd0;
    rf_wr_tag    = 4'd0;
    flush        = 1'b0;
    redirect_pc  = 32'd0;
    timer_load   = 1'b0;
    timer_count  = 1'b0;
    eligible     = reset_n && !rob_empty && head_ready;

    unique case (state_q)
      RETIRE: begin
        if (eligible) begin
          case (head.itype)
            ITYPE_ALU, ITYPE_LOAD: begin
              rd_en      = 1'b1;
              rf_wr_en   = 1'b1;
              rf_wr_addr = head.dest_reg;
              rf_wr_data = head.value;
              rf_wr_tag  = head.ROB_number;
            end
            ITYPE_STORE: begin
              store_addr_d = head.addr;
              store_data_d = head.value;
              state_d      = STORE_WAIT;
            end
            default: begin
              rd_en = 1'b1;
              if (head.branch_result) begin
                flush       = 1'b1;
                redirect_pc = head.value;
                timer_load  = 1'b1;
                state_d     = FLUSH_WAIT;
              end
            end
          endcase
        end
      end
      STORE_WAIT: begin
        if (store_ack && reset_n) begin
          rd_en   = 1'b1;
          state_d = RETIRE;
        end
      end
      FLUSH_WAIT: begin
        timer_count = 1'b1;
        if (timer_zero) begin
          state_d = RETIRE;
        end
      end
      default: state_d = RETIRE;
    endcase

    store_req_d     = (state_d == STORE_WAIT);
    retired_count_d = retired_count_q + CNT_W'(rd_en);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= RETIRE;
      store_req_q     <= 1'b0;
      store_addr_q    <= 32'd0;
      store_data_q    <= 32'd0;
      retired_count_q <= '0;
    end else begin
      state_q         <= state_d;
      store_req_q     <= store_req_d;
      store_addr_q    <= store_addr_d;
      store_data_q    <= store_data_d;
      retired_count_q <= retired_count_d;
    end
  end

  assign store_req     = store_req_q;
  assign store_addr    = store_addr_q;
  assign store_data    = store_data_q;
  assign retired_count = retired_count_q;

endmodule

// File: tb/tb_commit_unit.sv
// Self-checking bench for commit_unit: directed scenarios then random traffic against a
// cycle-indexed retirement model.
module tb_commit_unit;
  import commit_unit_pkg::*;

  localparam int unsigned FC = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  ROB_entry_t  head;
  logic        head_ready;
  logic        rob_empty;
  logic        store_ack;

  logic        rd_en, rf_wr_en, store_req, flush;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data, store_addr, store_data, redirect_pc;
  logic [3:0]  rf_wr_tag;
  logic [31:0] retired_count;

  logic        s_rd_en, s_rf_wr_en, s_store_req, s_flush;
  logic [4:0]  s_rf_wr_addr;
  logic [31:0] s_rf_wr_data, s_store_addr, s_store_data, s_redirect_pc;
  logic [3:0]  s_rf_wr_tag;
  logic [3:0]  s_retired_count;

  always #5 clk = ~clk;

  commit_unit #(.FLUSH_CYCLES(FC), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .head(head), .head_ready(head_ready),
    .rob_empty(rob_empty), .store_ack(store_ack), .rd_en(rd_en),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .rf_wr_tag(rf_wr_tag), .store_req(store_req), .store_addr(store_addr),
    .store_data(store_data), .flush(flush), .redirect_pc(redirect_pc),
    .retired_count(retired_count)
  );

  // Narrow counter instance so wrap-around is reachable in a short run
  commit_unit #(.FLUSH_CYCLES(FC), .CNT_W(4)) dut_small (
    .clk(clk), .reset_n(reset_n), .head(head), .head_ready(head_ready),
    .rob_empty(rob_empty), .store_ack(store_ack), .rd_en(s_rd_en),
    .rf_wr_en(s_rf_wr_en), .rf_wr_addr(s_rf_wr_addr), .rf_wr_data(s_rf_wr_data),
    .rf_wr_tag(s_rf_wr_tag), .store_req(s_store_req), .store_addr(s_store_addr),
    .store_data(s_store_data), .flush(s_flush), .redirect_pc(s_redirect_pc),
    .retired_count(s_retired_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: retirement allowed from cycle resume_at onward, one pending store at most
  int          cyc = 0;
  int          resume_at = 0;
  bit          st_pend = 0;
  logic [31:0] st_addr = 0;
  logic [31:0] st_data = 0;
  logic [31:0] cnt = 0;
  int          req_hi = 0;

  task automatic model_reset();
    st_pend   = 0;
    st_addr   = 0;
    st_data   = 0;
    cnt       = 0;
    resume_at = cyc;
  endtask

  // Called just after a falling edge: drive, check, then let one rising edge pass
  task automatic step(input logic [1:0] it, input logic rdy, input logic [4:0] dr,
                      input logic [31:0] val, input logic [31:0] ad, input logic br,
                      input logic [3:0] tag, input logic empty, input logic ack);
    bit e_rd, e_wr, e_fl, e_st;
    head.itype         = it;
    head.ready         = rdy;
    head.dest_reg      = dr;
    head.value         = val;
    head.addr          = ad;
    head.branch_result = br;
    head.ROB_number    = tag;
    head_ready         = rdy;
    rob_empty          = empty;
    store_ack          = ack;
    #1;
    e_rd = 0; e_wr = 0; e_fl = 0; e_st = 0;
    if (st_pend) begin
      e_rd = ack;
    end else if (cyc >= resume_at && !empty && rdy) begin
      if (it == ITYPE_ALU || it == ITYPE_LOAD) begin
        e_rd = 1; e_wr = 1;
      end else if (it == ITYPE_STORE) begin
        e_st = 1;
      end else begin
        e_rd = 1; e_fl = br;
      end
    end
    check_eq("rd_en", rd_en, e_rd);
    check_eq("rf_wr_en", rf_wr_en, e_wr);
    if (e_wr) begin
      check_eq("rf_wr_addr", rf_wr_addr, dr);
      check_eq("rf_wr_data", rf_wr_data, val);
      check_eq("rf_wr_tag", rf_wr_tag, tag);
    end
    check_eq("flush", flush, e_fl);
    if (e_fl) check_eq("redirect_pc", redirect_pc, val);
    check_eq("store_req", store_req, st_pend);
    check_eq("store_addr", store_addr, st_addr);
    check_eq("store_data", store_data, st_data);
    check_eq("retired_count", retired_count, cnt);
    check_eq("small_rd_en", s_rd_en, e_rd);
    check_eq("small_retired_count", s_retired_count, cnt[3:0]);
    if (store_req) req_hi++;
    @(posedge clk);
    if (e_rd) cnt = cnt + 1;
    if (st_pend && ack) st_pend = 0;
    if (e_st) begin
      st_pend = 1; st_addr = ad; st_data = val;
    end
    if (e_fl) resume_at = cyc + 1 + FC;
    cyc++;
    @(negedge clk);
  endtask

  task automatic alu(input logic [4:0] dr, input logic [31:0] val, input logic [3:0] tag);
    step(ITYPE_ALU, 1, dr, val, 32'd0, 0, tag, 0, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst_store_req", store_req, 0);
    check_eq("rst_retired_count", retired_count, 0);
    check_eq("rst_rd_en", rd_en, 0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc++;
    model_reset();
  endtask

  initial begin
    reset_n    = 1'b0;
    head       = '0;
    head_ready = 1'b0;
    rob_empty  = 1'b1;
    store_ack  = 1'b0;
    @(negedge clk);
    // Ready ALU head under reset must not retire
    head.itype = ITYPE_ALU; head.ready = 1; head_ready = 1; rob_empty = 0;
    #1;
    check_eq("reset_rd_en", rd_en, 0);
    check_eq("reset_rf_wr_en", rf_wr_en, 0);
    check_eq("reset_store_req", store_req, 0);
    check_eq("reset_count", retired_count, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // ALU retirement
    alu(5'd5, 32'hDEAD_BEEF, 4'd3);
    check_eq("alu_count_after", retired_count, 1);

    // Store with ack after 3 wait cycles; head changes underneath
    req_hi = 0;
    step(ITYPE_STORE, 1, 0, 32'h55, 32'h100, 0, 0, 0, 0);
    step(ITYPE_ALU, 1, 1, 32'h1, 32'h0, 0, 1, 0, 0);
    step(ITYPE_ALU, 1, 1, 32'h1, 32'h0, 0, 1, 0, 0);
    step(ITYPE_ALU, 1, 1, 32'h1, 32'h0, 0, 1, 0, 1);
    step(ITYPE_ALU, 0, 1, 32'h1, 32'h0, 0, 1, 0, 1);
    check_eq("store_req_cycles", req_hi, 3);
    check_eq("store_addr_latched", store_addr, 32'h100);

    // Mispredict then stalled ready heads
    step(ITYPE_BRANCH, 1, 0, 32'h2000, 0, 1, 7, 0, 0);
    alu(5'd2, 32'h11, 4'd2);
    alu(5'd2, 32'h11, 4'd2);
    alu(5'd2, 32'h12, 4'd4);
    check_eq("count_after_flush", retired_count, 4);

    // Stale entry, not ready, correctly predicted branch
    step(ITYPE_ALU, 1, 3, 32'h9, 0, 0, 1, 1, 0);
    step(ITYPE_ALU, 0, 3, 32'h9, 0, 0, 1, 0, 0);
    step(ITYPE_BRANCH, 1, 0, 32'h3000, 0, 0, 5, 0, 0);
    step(ITYPE_LOAD, 1, 0, 32'h77, 0, 0, 6, 0, 0);

    // Reset in the 2nd STORE_WAIT cycle
    step(ITYPE_STORE, 1, 0, 32'hAA, 32'h200, 0, 0, 0, 0);
    step(ITYPE_ALU, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    check_eq("post_rst_store_addr", store_addr, 0);
    step(ITYPE_ALU, 0, 0, 0, 0, 0, 0, 0, 1);
    alu(5'd9, 32'hCAFE, 4'd9);
    check_eq("post_rst_count", retired_count, 1);

    // Wrap of the narrow counter after 16 back-to-back retirements
    do_reset();
    for (int i = 0; i < 16; i++) alu(5'(i), 32'(i), 4'(i));
    check_eq("small_wrap", s_retired_count, 0);
    check_eq("wide_after_16", retired_count, 16);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), 5'($urandom),
           32'($urandom), 32'($urandom), ($urandom_range(0, 2) == 0), 4'($urandom),
           ($urandom_range(0, 6) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
